object_bbox_tracker: RTL and testbench

Consumes the thresholded object-mask stream from the object extraction stage and reduces each frame to a bounding box, object pixel count and integer centroid. Results are published once per frame, a fixed number of cycles after frame end, for the overlay and servo-control logic downstream. Per-frame accumulation and the centroid divider run concurrently, so back-to-back frames with short blanking are handled.

---
 rtl/object_bbox_tracker.sv | 220 ++++++++++++++++++++++
 tb/tb_object_bbox_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/object_bbox_tracker.sv
// object_bbox_tracker: reduces a thresholded object-mask stream to a per-frame
// bounding box, object pixel count and integer centroid. Accumulation of the
// next frame overlaps the centroid division of the previous one.
module object_bbox_tracker #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        object_pixel,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pixel_valid,
  input  logic        frame_valid,
  output logic [9:0]  bbox_x_min,
  output logic [9:0]  bbox_x_max,
  output logic [9:0]  bbox_y_min,
  output logic [9:0]  bbox_y_max,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic [18:0] obj_count,
  output logic        obj_found,
  output logic        result_valid,
  output logic        overrun,
  output logic        busy
);

  localparam logic [10:0] H_LIM     = 11'(H_RES);
  localparam logic [10:0] V_LIM     = 11'(V_RES);
  localparam logic [18:0] MIN_CNT   = 19'(MIN_PIXELS);
  localparam logic [4:0]  LAST_ITER = 5'd27;

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, DIV, PUBLISH} state_t;

  state_t      state, state_next;
  logic        frame_valid_d;
  logic        in_frame;
  logic        sof, eof, accept;
  logic        take_snap;

  // accumulators for the frame currently arriving
  logic [18:0] cnt;
  logic [27:0] sum_x, sum_y;
  logic [9:0]  xmin, xmax, ymin, ymax;

  // snapshot of the frame being divided / published
  logic [18:0] cnt_snap;
  logic [9:0]  xmin_s, xmax_s, ymin_s, ymax_s;

  // restoring dividers: numerator shift register, partial remainder, quotient
  logic [27:0] num_x, num_y;
  logic [18:0] rem_x, rem_y;
  logic [9:0]  q_x, q_y;
  logic [4:0]  iter;
  logic [19:0] trial_x, trial_y;
  logic        ge_x, ge_y;
  logic        found;

  assign sof    = frame_valid & ~frame_valid_d;
  assign eof    = ~frame_valid & frame_valid_d;
  assign accept = pixel_valid & frame_valid & object_pixel &
                  ({1'b0, x} < H_LIM) & ({1'b0, y} < V_LIM);
  assign found  = (cnt_snap >= MIN_CNT);

  // frame_valid history follows the input even in reset, so a frame already
  // running when reset releases never looks like a start of frame
  always_ff @(posedge clk) begin
    frame_valid_d <= frame_valid;
  end

  // state register plus frame-in-progress flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WAIT_SOF;
      in_frame <= 1'b0;
    end else begin
      state <= state_next;
      if (sof)      in_frame <= 1'b1;
      else if (eof) in_frame <= 1'b0;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SOF: if (sof) state_next = ACCUM;
      ACCUM:    if (eof) state_next = DIV;
      DIV:      if (iter == LAST_ITER) state_next = PUBLISH;
      PUBLISH: begin
        if (eof)                 state_next = DIV;
        else if (in_frame | sof) state_next = ACCUM;
        else                     state_next = WAIT_SOF;
      end
      default:  state_next = WAIT_SOF;
    endcase
  end

  // FSM outputs; an EOF landing in PUBLISH can still be snapshotted because
  // the result registers read the old snapshot on that same edge
  always_comb begin
    busy      = 1'b0;
    overrun   = 1'b0;
    take_snap = 1'b0;
    case (state)
      DIV: begin
        busy    = 1'b1;
        overrun = eof & rst_n;
      end
      ACCUM:   take_snap = eof;
      PUBLISH: take_snap = eof;
      default: ;
    endcase
  end

  // per-frame accumulation; SOF reloads initial values so nothing leaks across frames
  always_ff @(posedge clk) begin
    if (!rst_n || eof) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      xmin  <= '1;
      xmax  <= '0;
      ymin  <= '1;
      ymax  <= '0;
    end else if (sof) begin
      cnt   <= accept ? 19'd1 : '0;
      sum_x <= accept ? 28'(x) : '0;
      sum_y <= accept ? 28'(y) : '0;
      xmin  <= accept ? x : '1;
      xmax  <= accept ? x : '0;
      ymin  <= accept ? y : '1;
      ymax  <= accept ? y : '0;
    end else if (accept) begin
      cnt   <= cnt + 19'd1;
      sum_x <= sum_x + 28'(x);
      sum_y <= sum_y + 28'(y);
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
    end
  end

  // one restoring-division trial step per divider
  always_comb begin
    trial_x = {rem_x, num_x[27]};
    trial_y = {rem_y, num_y[27]};
    ge_x    = (trial_x >= {1'b0, cnt_snap});
    ge_y    = (trial_y >= {1'b0, cnt_snap});
  end

  // snapshot capture and the 28-cycle MSB-first divide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_snap <= '0;
      xmin_s   <= '0;
      xmax_s   <= '0;
      ymin_s   <= '0;
      ymax_s   <= '0;
      num_x    <= '0;
      num_y    <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      q_x      <= '0;
      q_y      <= '0;
      iter     <= '0;
    end else if (take_snap) begin
      cnt_snap <= cnt;
      xmin_s   <= xmin;
      xmax_s   <= xmax;
      ymin_s   <= ymin;
      ymax_s   <= ymax;
      num_x    <= sum_x;
      num_y    <= sum_y;
      rem_x    <= '0;
      rem_y    <= '0;
      q_x      <= '0;
      q_y      <= '0;
      iter     <= '0;
    end else if (state == DIV) begin
      num_x <= {num_x[26:0], 1'b0};
      num_y <= {num_y[26:0], 1'b0};
      rem_x <= ge_x ? 19'(trial_x - {1'b0, cnt_snap}) : trial_x[18:0];
      rem_y <= ge_y ? 19'(trial_y - {1'b0, cnt_snap}) : trial_y[18:0];
      q_x   <= {q_x[8:0], ge_x};
      q_y   <= {q_y[8:0], ge_y};
      iter  <= iter + 5'd1;
    end
  end

  // result registers, loaded only in PUBLISH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bbox_x_min   <= '0;
      bbox_x_max   <= '0;
      bbox_y_min   <= '0;
      bbox_y_max   <= '0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      obj_count    <= '0;
      obj_found    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        obj_count  <= cnt_snap;
        obj_found  <= found;
        bbox_x_min <= found ? xmin_s : '0;
        bbox_x_max <= found ? xmax_s : '0;
        bbox_y_min <= found ? ymin_s : '0;
        bbox_y_max <= found ? ymax_s : '0;
        centroid_x <= found ? q_x : '0;
        centroid_y <= found ? q_y : '0;
      end
    end
  end

endmodule

// File: tb/tb_object_bbox_tracker.sv
// Scoreboard bench for object_bbox_tracker: a behavioural model predicts each
// frame's result when its EOF is driven; a monitor pops and compares on result_valid.
module tb_object_bbox_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        object_pixel = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pixel_valid = 1'b0;
  logic        frame_valid = 1'b0;
  logic [9:0]  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [9:0]  centroid_x, centroid_y;
  logic [18:0] obj_count;
  logic        obj_found, result_valid, overrun, busy;

  object_bbox_tracker #(.H_RES(640), .V_RES(480), .MIN_PIXELS(16)) dut (
    .clk(clk), .rst_n(rst_n), .object_pixel(object_pixel), .x(x), .y(y),
    .pixel_valid(pixel_valid), .frame_valid(frame_valid),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .centroid_x(centroid_x), .centroid_y(centroid_y),
    .obj_count(obj_count), .obj_found(obj_found),
    .result_valid(result_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int xmin, xmax, ymin, ymax;
    int cx, cy, cnt, found;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ov_seen = 0;
  int   ov_expected = 0;

  // model state
  bit   m_fv_d = 1'b0;
  bit   m_sync = 1'b0;
  int   m_snap = -1000;
  int   m_cnt, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax;
  bit   m_exp_ov, m_exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic m_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
  endtask

  task automatic m_frame_end();
    exp_t e;
    m_exp_ov = 1'b0;
    if (!m_sync) return;
    if (cyc >= m_snap + 1 && cyc <= m_snap + 28) begin
      m_exp_ov = 1'b1;
      ov_expected++;
    end else begin
      e.cyc   = cyc + 30;
      e.cnt   = m_cnt;
      e.found = (m_cnt >= 16) ? 1 : 0;
      e.xmin  = e.found ? m_xmin : 0;
      e.xmax  = e.found ? m_xmax : 0;
      e.ymin  = e.found ? m_ymin : 0;
      e.ymax  = e.found ? m_ymax : 0;
      e.cx    = e.found ? m_sx / m_cnt : 0;
      e.cy    = e.found ? m_sy / m_cnt : 0;
      sb.push_back(e);
      m_snap  = cyc;
    end
  endtask

  // drive one cycle of input and advance the model with what the DUT will sample
  task automatic step(input bit pv, input bit fv, input bit obj, input int px, input int py);
    bit acc;
    @(posedge clk);
    #1;
    pixel_valid  = pv;
    frame_valid  = fv;
    object_pixel = obj;
    x = px[9:0];
    y = py[9:0];
    m_exp_busy = (cyc >= m_snap + 1 && cyc <= m_snap + 28);
    m_exp_ov   = 1'b0;
    acc = pv && fv && obj && px < 640 && py < 480;
    if (rst_n) begin
      if (fv && !m_fv_d) begin
        m_sync = 1'b1;
        m_clear();
      end
      if (!fv && m_fv_d) begin
        m_frame_end();
        m_clear();
      end
      if (acc) begin
        m_cnt++;
        m_sx += px;
        m_sy += py;
        if (px < m_xmin) m_xmin = px;
        if (px > m_xmax) m_xmax = px;
        if (py < m_ymin) m_ymin = py;
        if (py > m_ymax) m_ymax = py;
      end
    end
    m_fv_d = fv;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // EOF cycle carries an object pixel that must be excluded
  task automatic end_frame(input int px, input int py);
    step(1'b1, 1'b0, 1'b1, px, py);
    @(negedge clk);
    check("overrun_at_eof", overrun, m_exp_ov);
    check("busy_at_eof", busy, m_exp_busy);
  endtask

  task automatic send_frame(input int ox, input int oy, input int ow, input int oh, input int lim);
    int n = 0;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        step(1'b1, 1'b1, (n < lim), ox + c, oy + r);
        n++;
      end
    step(1'b1, 1'b1, 1'b1, 700, oy);
    step(1'b1, 1'b1, 1'b1, ox, 500);
    step(1'b0, 1'b1, 1'b1, ox + 1, oy + 1);
    step(1'b1, 1'b1, 1'b0, ox + 2, oy);
    end_frame(ox, oy);
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    sb.delete();
    m_sync = 1'b0;
    m_snap = -1000;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_xmin"}, bbox_x_min, 0);
    check({tag, "_xmax"}, bbox_x_max, 0);
    check({tag, "_ymin"}, bbox_y_min, 0);
    check({tag, "_ymax"}, bbox_y_max, 0);
    check({tag, "_cx"}, centroid_x, 0);
    check({tag, "_cy"}, centroid_y, 0);
    check({tag, "_cnt"}, obj_count, 0);
    check({tag, "_found"}, obj_found, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_ov"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // result monitor: every pulse must match the oldest predicted frame
  exp_t mon_e;
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_seen++;
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_result_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rv_latency_cycle", cyc, mon_e.cyc);
        check("obj_count", obj_count, mon_e.cnt);
        check("obj_found", obj_found, mon_e.found);
        check("bbox_x_min", bbox_x_min, mon_e.xmin);
        check("bbox_x_max", bbox_x_max, mon_e.xmax);
        check("bbox_y_min", bbox_y_min, mon_e.ymin);
        check("bbox_y_max", bbox_y_max, mon_e.ymax);
        check("centroid_x", centroid_x, mon_e.cx);
        check("centroid_y", centroid_y, mon_e.cy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // single 4x4 object
    send_frame(100, 50, 4, 4, 16);
    blank(40);
    // 15 object pixels: below threshold
    send_frame(300, 200, 4, 4, 15);
    blank(40);
    // empty frame
    send_frame(10, 10, 4, 4, 0);
    blank(40);
    // back-to-back frames with a 10-cycle gap
    send_frame(100, 50, 4, 4, 16);
    blank(10);
    send_frame(600, 400, 4, 4, 16);
    blank(40);
    // short frame ending during DIV
    send_frame(20, 30, 4, 4, 16);
    blank(2);
    send_frame(200, 100, 2, 2, 4);
    blank(40);
    send_frame(50, 60, 3, 6, 18);
    blank(40);

    // reset in the middle of a frame; remainder of that frame is ignored
    step(1'b1, 1'b1, 1'b1, 400, 300);
    step(1'b1, 1'b1, 1'b1, 401, 300);
    enter_reset();
    step(1'b1, 1'b1, 1'b1, 402, 300);
    step(1'b1, 1'b1, 1'b1, 403, 300);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("rst_frame");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 404 + (i % 4), 301 + (i / 4));
    end_frame(404, 301);
    blank(40);

    // reset in the middle of a division
    send_frame(100, 50, 4, 4, 16);
    blank(10);
    enter_reset();
    blank(2);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("rst_div");
    blank(40);
    send_frame(5, 470, 4, 4, 16);
    blank(40);

    check("scoreboard_drained", sb.size(), 0);
    check("overrun_pulse_total", ov_seen, ov_expected);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
